// File: rtl/loader_pkg.sv
// Shared definitions for the program loader / run monitor: FSM states,
// the sim-end store signature and the default SRAM depth.
package loader_pkg;

  localparam int DEFAULT_WORD_CNT = 16384;

  localparam logic [13:0] SIM_END_ADDR = 14'h3fff;
  localparam logic [31:0] SIM_END_CODE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_RUN     = 3'd3,
    ST_FINISH  = 3'd4,
    ST_TIMEOUT = 3'd5
  } ldr_state_e;

endpackage

// File: rtl/prog_loader_monitor_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; a short final word
// is zero-padded. word_valid pulses for one cycle per completed word.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        fire,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] acc;
  logic [31:0] assembled;

  // Upper lanes of acc are always zero until written, which gives the padding.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    assembled = {8'h00, acc};
    assembled[{lane, 3'b000} +: 8] = in_byte;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= 2'd0;
      acc        <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= 2'd0;
        acc  <= 24'd0;
      end else if (fire) begin
        if (lane == 2'd3 || in_last) begin
          word       <= assembled;
          word_valid <= 1'b1;
          lane       <= 2'd0;
          acc        <= 24'd0;
        end else begin
          acc  <= assembled[23:0];
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader_monitor.sv
// Loads a byte-stream program image into IM and DM, then runs the core
// and watches its DM stores for the sim-end signature or a cycle timeout.
module prog_loader_monitor
  import loader_pkg::*;
#(
  parameter int WORD_CNT   = DEFAULT_WORD_CNT,
  parameter int ADDR_W     = 14,
  parameter int MAX_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              im_we,
  output logic              dm_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  input  logic              mon_we,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [31:0]       mon_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic [63:0]       cycle_count,
  output logic              done,
  output logic              timeout,
  output logic              overflow
);

  ldr_state_e  state, state_nxt;
  logic        fire, load_go, full, sim_end, budget_hit;
  logic [31:0] word;
  logic        word_valid;

  assign fire       = in_valid & in_ready;
  assign load_go    = start & (state == ST_IDLE || state == ST_FINISH || state == ST_TIMEOUT);
  assign full       = (words_loaded == (ADDR_W+1)'(WORD_CNT));
  assign sim_end    = mon_we && (mon_addr == ADDR_W'(SIM_END_ADDR)) && (mon_wdata == SIM_END_CODE);
  assign budget_hit = (cycle_count + 64'd1 == 64'(MAX_CYCLES));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_go),
    .fire       (fire),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .word       (word),
    .word_valid (word_valid)
  );

  // Words past the SRAM depth are dropped; address equals words written so far.
  assign im_we     = word_valid & ~full;
  assign dm_we     = word_valid & ~full;
  assign mem_addr  = words_loaded[ADDR_W-1:0];
  assign mem_wdata = word;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_FINISH, ST_TIMEOUT: if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (fire && in_last) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
      ST_RUN: begin
        if (sim_end)         state_nxt = ST_FINISH;
        else if (budget_hit) state_nxt = ST_TIMEOUT;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // core_rst and in_ready are registered from the next state to keep them glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      core_rst     <= 1'b1;
      in_ready     <= 1'b0;
      words_loaded <= '0;
      cycle_count  <= 64'd0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state    <= state_nxt;
      core_rst <= (state_nxt != ST_RUN);
      in_ready <= (state_nxt == ST_LOAD);
      if (load_go) begin
        words_loaded <= '0;
        cycle_count  <= 64'd0;
        done         <= 1'b0;
        timeout      <= 1'b0;
        overflow     <= 1'b0;
      end else begin
        if (word_valid) begin
          if (full) overflow     <= 1'b1;
          else      words_loaded <= words_loaded + 1'b1;
        end
        if (state == ST_RUN) begin
          cycle_count <= cycle_count + 64'd1;
          if (sim_end)         done    <= 1'b1;
          else if (budget_hit) timeout <= 1'b1;
        end
      end
    end
  end

endmodule
